// File: rtl/mux4_rr_arbiter_if.sv
// Requester/mux-side bundle for the 4:1 mux arbiter: ena and req go in; grant, select, valid and hold count come out.
interface mux4_rr_arbiter_if #(
  parameter int CNT_W = 4
);
  logic             ena;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             valid;
  logic [CNT_W-1:0] hold_cnt;

  modport master (output ena, req, input gnt, sel, valid, hold_cnt);
  modport slave  (input ena, req, output gnt, sel, valid, hold_cnt);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin sequencer for the 4:1 mux select: 1-edge request-to-grant, bounded hold, one dead cycle per handoff.
// Requests are level-held with no backpressure; `define MUX4_ARB_PRIO_EN makes req[0] high priority and preemptive.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [3:0]       gnt, gnt_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [1:0]       last, last_nxt;
  logic             valid, valid_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [1:0]       pick;
  logic             pick_vld;
  logic             release_gnt;

  // Search starts just after the last granted index and wraps; k=4 lands back on last itself.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!pick_vld && bus.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
`ifdef MUX4_ARB_PRIO_EN
    if (bus.req[0]) begin
      pick     = 2'd0;
      pick_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    release_gnt = !bus.req[sel] || !bus.ena ||
                  ((hold_cnt == HOLD_LIM) && |(bus.req & ~gnt));
`ifdef MUX4_ARB_PRIO_EN
    if ((sel != 2'd0) && bus.req[0]) begin
      release_gnt = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    last_nxt  = last;
    valid_nxt = valid;
    hold_nxt  = hold_cnt;
    unique case (state)
      IDLE, GAP: begin
        // GAP arbitrates exactly like IDLE but always leaves after one cycle.
        if (bus.ena && pick_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << pick;
          sel_nxt   = pick;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
          hold_nxt  = '0;
          last_nxt  = sel;
        end else if (hold_cnt != HOLD_LIM) begin
          hold_nxt  = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      last     <= 2'd3;
      valid    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      valid    <= valid_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.sel      = sel;
  assign bus.valid    = valid;
  assign bus.hold_cnt = hold_cnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboarded random + directed bench for mux4_rr_arbiter against an ownership-level reference model.
module tb_mux4_rr_arbiter;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.CNT_W(CNT_W)) bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int gnt;
    int sel;
    int valid;
    int hold;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: who owns the mux (if anyone), for how long, and who was served last.
  bit m_busy;
  int m_sel;
  int m_hold;
  int m_last;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_hold = 0;
    m_last = 3;
    q.delete();
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
`ifdef MUX4_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      logic [3:0] r;
      bit         others;
      bit         rel;
      exp_t       e;
      r = bus.req;
      if (m_busy) begin
        others = (r & ~(4'b0001 << m_sel)) != 4'b0000;
        rel = !r[m_sel] || !bus.ena || (m_hold == MAX_HOLD - 1 && others);
`ifdef MUX4_ARB_PRIO_EN
        if (m_sel != 0 && r[0]) rel = 1'b1;
`endif
        if (rel) begin
          m_busy = 1'b0;
          m_last = m_sel;
          m_hold = 0;
        end else if (m_hold < MAX_HOLD - 1) begin
          m_hold++;
        end
      end else if (bus.ena && r != 4'b0000) begin
        m_sel  = rr_pick(r, m_last);
        m_busy = 1'b1;
        m_hold = 0;
      end
      e.gnt   = m_busy ? (1 << m_sel) : 0;
      e.sel   = m_sel;
      e.valid = m_busy ? 1 : 0;
      e.hold  = m_hold;
      q.push_back(e);
    end
  end

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("sb_gnt",   int'(bus.gnt),      e.gnt);
      check("sb_sel",   int'(bus.sel),      e.sel);
      check("sb_valid", int'(bus.valid),    e.valid);
      check("sb_hold",  int'(bus.hold_cnt), e.hold);
    end
  end

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_gnt"},   int'(bus.gnt),      0);
    check({tag, "_sel"},   int'(bus.sel),      0);
    check({tag, "_valid"}, int'(bus.valid),    0);
    check({tag, "_hold"},  int'(bus.hold_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    bus.req = 4'b0000;
    bus.ena = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    model_reset();
    bus.ena = 1'b0;
    bus.req = 4'b0000;
    #12;
    reset_now("rst");

    // Single requester, then drop.
    bus.ena = 1'b1;
    bus.req = 4'b0100;
    @(posedge clk); #2;
    check("single_gnt", int'(bus.gnt), 4);
    check("single_sel", int'(bus.sel), 2);
    check("single_vld", int'(bus.valid), 1);
    @(negedge clk);
    bus.req = 4'b0000;
    @(posedge clk); #2;
    check("drop_gnt", int'(bus.gnt), 0);
    check("drop_sel", int'(bus.sel), 2);
    check("drop_vld", int'(bus.valid), 0);

    // Reset between edges while sel=2 is granted.
    idle_cycles(2);
    bus.req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("pre_rst_gnt", int'(bus.gnt), 4);
    reset_now("midrst");

    // Full contention: 8 cycles each plus one dead cycle, order 0,1,2,3,0.
    bus.ena = 1'b1;
    bus.req = 4'b1111;
    @(posedge clk); #2;
    check("cont_first", int'(bus.gnt), 1);
    repeat (9) @(posedge clk);
    #2;
    check("cont_second", int'(bus.gnt), 2);
    repeat (9) @(posedge clk);
    #2;
    check("cont_third", int'(bus.gnt), 4);
    repeat (24) @(negedge clk);

    // Hold saturation with a lone requester, then a competitor arrives.
    idle_cycles(3);
    bus.req = 4'b0010;
    repeat (20) @(posedge clk);
    #2;
    check("sat_hold", int'(bus.hold_cnt), MAX_HOLD - 1);
    check("sat_gnt",  int'(bus.gnt), 2);
    @(negedge clk);
    bus.req = 4'b1010;
    @(posedge clk); #2;
    check("sat_gap", int'(bus.gnt), 0);
    @(posedge clk); #2;
    check("sat_next_gnt", int'(bus.gnt), 8);
    check("sat_next_sel", int'(bus.sel), 3);

    // Enable drop during a grant on index 1.
    idle_cycles(3);
    bus.req = 4'b0110;
    @(posedge clk); #2;
    check("ena_gnt1", int'(bus.gnt), 2);
    @(negedge clk);
    bus.ena = 1'b0;
    @(posedge clk); #2;
    check("ena_off_gnt", int'(bus.gnt), 0);
    repeat (3) @(posedge clk);
    #2;
    check("ena_off_hold", int'(bus.valid), 0);
    @(negedge clk);
    bus.ena = 1'b1;
    @(posedge clk); #2;
    check("ena_back_sel", int'(bus.sel), 2);

    // Preemption scenario; the scoreboard covers both build variants.
    idle_cycles(3);
    bus.req = 4'b0010;
    repeat (3) @(negedge clk);
    bus.req = 4'b0011;
    repeat (12) @(negedge clk);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.ena = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset_now("rndrst");
      end
    end

    idle_cycles(3);
    @(posedge clk); #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
